// File: rtl/span_painter_if.sv
// Painter-side bundle: PRAM queue pointers/data plus the frame-buffer write port.
// master = painter (drives rd_ptr, full, fb_*, busy); slave = queue/frame-buffer side.
interface span_painter_if #(
    parameter int PTR_W   = 10,
    parameter int DATA_W  = 18,
    parameter int ADDR_W  = 15,
    parameter int COLOR_W = 3
);
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [DATA_W-1:0]  cmd_data;
    logic               full;
    logic               fb_ready;
    logic               fb_we;
    logic [ADDR_W-1:0]  fb_addr;
    logic [COLOR_W-1:0] fb_data;
    logic               busy;

    modport master (
        input  wr_ptr, cmd_data, fb_ready,
        output rd_ptr, full, fb_we, fb_addr, fb_data, busy
    );

    modport slave (
        output wr_ptr, cmd_data, fb_ready,
        input  rd_ptr, full, fb_we, fb_addr, fb_data, busy
    );
endinterface

// File: rtl/span_painter.sv
// Drains two-word draw commands (SPAN/RECT/CLEAR/NOP) from the PRAM queue and
// emits one frame-buffer pixel write per accepted cycle. Ports: clk, reset (async, active-low), bus (master).
module span_painter #(
    parameter int H_RES   = 160,
    parameter int V_RES   = 120,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3,
    parameter int PTR_W   = 10,
    parameter int DATA_W  = 18,
    parameter int ADDR_W  = 15
) (
    input  logic          clk,
    input  logic          reset,
    span_painter_if.master bus
);

    typedef enum logic [1:0] {FETCH0, FETCH1, SETUP, PAINT} state_t;

    localparam logic [1:0] OP_SPAN  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    localparam logic [X_W-1:0]    X_MAX    = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]    Y_MAX    = Y_W'(V_RES - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

    state_t state, state_n;

    logic [PTR_W-1:0]   rd_ptr;
    logic [DATA_W-1:0]  w0, w1;
    logic [X_W-1:0]     x, x_l, x_r;
    logic [Y_W-1:0]     row, y_b;
    logic [ADDR_W-1:0]  base;
    logic [COLOR_W-1:0] color;

    logic               empty, last, drop;
    logic [1:0]         c_op;
    logic [X_W-1:0]     c_l, c_r;
    logic [Y_W-1:0]     c_t, c_b;
    logic [COLOR_W-1:0] c_color;

    assign empty = (bus.wr_ptr == rd_ptr);
    assign last  = (x == x_r) && (row == y_b);

    // Decode and clamp the latched command; CLEAR is rewritten as a full-screen rect.
    always_comb begin
        c_op    = w0[DATA_W-1 -: 2];
        c_l     = w0[2*X_W-1:X_W];
        c_r     = w0[X_W-1:0];
        c_t     = w1[2*Y_W+COLOR_W-1:Y_W+COLOR_W];
        c_b     = w1[Y_W+COLOR_W-1:COLOR_W];
        c_color = w1[COLOR_W-1:0];
        if (c_op == OP_CLEAR) begin
            c_l = '0;
            c_r = X_MAX;
            c_t = '0;
            c_b = Y_MAX;
        end
        if (c_r > X_MAX) c_r = X_MAX;
        if (c_b > Y_MAX) c_b = Y_MAX;
        if (c_op == OP_SPAN) c_b = c_t;
        drop = (c_op == OP_NOP) || (c_l > X_MAX) || (c_t > Y_MAX)
            || (c_r < c_l) || (c_b < c_t);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH0;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            FETCH0: if (!empty) state_n = FETCH1;
            FETCH1: if (!empty) state_n = SETUP;
            SETUP:  state_n = drop ? FETCH0 : PAINT;
            PAINT:  if (bus.fb_ready && last) state_n = FETCH0;
            default: state_n = FETCH0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            w0     <= '0;
            w1     <= '0;
            x      <= '0;
            x_l    <= '0;
            x_r    <= '0;
            row    <= '0;
            y_b    <= '0;
            base   <= '0;
            color  <= '0;
        end else begin
            unique case (state)
                FETCH0: if (!empty) begin
                    w0     <= bus.cmd_data;
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                FETCH1: if (!empty) begin
                    w1     <= bus.cmd_data;
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                SETUP: if (!drop) begin
                    x     <= c_l;
                    x_l   <= c_l;
                    x_r   <= c_r;
                    row   <= c_t;
                    y_b   <= c_b;
                    base  <= ADDR_W'(c_t) * ROW_STEP;
                    color <= c_color;
                end
                PAINT: if (bus.fb_ready) begin
                    // Row advance by addition; base overshoots after the
                    // final pixel but fb_we is already low by then.
                    if (x == x_r) begin
                        x    <= x_l;
                        base <= base + ROW_STEP;
                        row  <= row + Y_W'(1);
                    end else begin
                        x <= x + X_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Ignored command-word bits.
    logic unused_bits;
    assign unused_bits = ^{w0, w1};

    assign bus.rd_ptr  = rd_ptr;
    assign bus.full    = ((bus.wr_ptr + PTR_ONE) == rd_ptr);
    assign bus.fb_we   = (state == PAINT);
    assign bus.fb_addr = base + ADDR_W'(x);
    assign bus.fb_data = color;
    assign bus.busy    = (state != FETCH0);

endmodule

// File: tb/tb_span_painter.sv
// Randomised and directed bench for span_painter against a pixel-list model.
// Ports exercised: clk, reset, full span_painter_if bundle.
module tb_span_painter;

    localparam int H = 160;
    localparam int V = 120;
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int COLOR_W = 3;
    localparam int PTR_W = 10;
    localparam int DATA_W = 18;
    localparam int ADDR_W = 15;
    localparam int DEPTH = 1 << PTR_W;

    logic clk = 1'b0;
    logic reset = 1'b0;

    span_painter_if #(
        .PTR_W(PTR_W), .DATA_W(DATA_W),
        .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)
    ) bus ();

    span_painter #(
        .H_RES(H), .V_RES(V), .X_W(X_W), .Y_W(Y_W),
        .COLOR_W(COLOR_W), .PTR_W(PTR_W),
        .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] pram [DEPTH];
    assign bus.cmd_data = pram[bus.rd_ptr];

    int compared = 0;
    int mismatched = 0;
    int exp_a[$];
    int exp_c[$];
    int acc_log[$];
    int stalls = 0;
    int ready_mode = 0;
    int ready_pat[$];

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] word0(input int op, input int l, input int r);
        logic [DATA_W-1:0] w;
        w = '0;
        w[DATA_W-1 -: 2] = 2'(op);
        w[2*X_W-1:X_W] = X_W'(l);
        w[X_W-1:0] = X_W'(r);
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] word1(input int t, input int b, input int c);
        logic [DATA_W-1:0] w;
        w = '0;
        w[2*Y_W+COLOR_W-1:Y_W+COLOR_W] = Y_W'(t);
        w[Y_W+COLOR_W-1:COLOR_W] = Y_W'(b);
        w[COLOR_W-1:0] = COLOR_W'(c);
        return w;
    endfunction

    // Pixel list a command must produce, straight from the drawing rules.
    task automatic model(input int op, input int l, input int r,
                         input int t, input int b, input int c);
        int rr, bb;
        if (op == 3) return;
        if (op == 2) begin
            for (int a = 0; a < H * V; a++) begin
                exp_a.push_back(a);
                exp_c.push_back(c);
            end
            return;
        end
        rr = (r > H - 1) ? H - 1 : r;
        bb = (op == 0) ? t : ((b > V - 1) ? V - 1 : b);
        if (l >= H || t >= V || rr < l || bb < t) return;
        for (int y = t; y <= bb; y++)
            for (int xx = l; xx <= rr; xx++) begin
                exp_a.push_back(y * H + xx);
                exp_c.push_back(c);
            end
    endtask

    task automatic put_cmd(input int op, input int l, input int r,
                           input int t, input int b, input int c, input int gap);
        model(op, l, r, t, b, c);
        pram[bus.wr_ptr] = word0(op, l, r);
        bus.wr_ptr = bus.wr_ptr + PTR_W'(1);
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #2;
        end
        pram[bus.wr_ptr] = word1(t, b, c);
        bus.wr_ptr = bus.wr_ptr + PTR_W'(1);
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_a.size() == 0 && !bus.busy && bus.wr_ptr == bus.rd_ptr) begin
                done = 1'b1;
                break;
            end
        end
        chk("idle_timeout", done, 1);
    endtask

    // Per-cycle compare of the write port against the head of the model list.
    initial forever begin
        @(negedge clk);
        if (reset && bus.fb_we) begin
            if (exp_a.size() == 0) begin
                chk("spurious_fb_we", bus.fb_we, 0);
            end else begin
                chk("fb_addr", bus.fb_addr, exp_a[0]);
                chk("fb_data", bus.fb_data, exp_c[0]);
                if (bus.fb_ready) begin
                    acc_log.push_back(int'(bus.fb_addr));
                    void'(exp_a.pop_front());
                    void'(exp_c.pop_front());
                end else begin
                    stalls++;
                end
            end
        end
    end

    initial begin
        bus.fb_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.fb_ready = 1'b1;
                1: bus.fb_ready = ($urandom_range(0, 3) != 0);
                default:
                    if (bus.fb_we && ready_pat.size() > 0)
                        bus.fb_ready = (ready_pat.pop_front() != 0);
                    else
                        bus.fb_ready = 1'b1;
            endcase
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int rp;
    int rect_exp[4] = '{19038, 19039, 19198, 19199};
    logic [PTR_W-1:0] used;

    initial begin
        int op, l, r, t, b;
        for (int i = 0; i < DEPTH; i++) pram[i] = '0;
        bus.wr_ptr = '0;
        #3;
        chk("rst_rd_ptr", bus.rd_ptr, 0);
        chk("rst_fb_we", bus.fb_we, 0);
        chk("rst_fb_addr", bus.fb_addr, 0);
        chk("rst_fb_data", bus.fb_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_full", bus.full, 0);
        @(negedge clk);
        reset = 1'b1;

        // SPAN: latency and five consecutive writes
        @(posedge clk);
        #2;
        acc_log.delete();
        rp = int'(bus.rd_ptr);
        put_cmd(0, 5, 9, 2, 2, 3, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("span_we_early", bus.fb_we, 0);
        @(posedge clk);
        @(negedge clk);
        chk("span_we_rise", bus.fb_we, 1);
        chk("span_first_addr", bus.fb_addr, 325);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("span_last_addr", bus.fb_addr, 329);
        chk("span_busy_last", bus.busy, 1);
        @(posedge clk);
        @(negedge clk);
        chk("span_done_we", bus.fb_we, 0);
        chk("span_done_busy", bus.busy, 0);
        chk("span_rd_ptr", bus.rd_ptr, rp + 2);
        chk("span_count", acc_log.size(), 5);
        for (int i = 0; i < acc_log.size() && i < 5; i++)
            chk("span_log", acc_log[i], 325 + i);

        // RECT clamped at the bottom-right corner
        acc_log.delete();
        @(posedge clk);
        #2;
        put_cmd(1, 158, 200, 118, 127, 5, 0);
        wait_idle(100);
        chk("rect_count", acc_log.size(), 4);
        for (int i = 0; i < acc_log.size() && i < 4; i++)
            chk("rect_log", acc_log[i], rect_exp[i]);

        // fb_ready 1,0,0,1 during a 4-pixel span
        acc_log.delete();
        stalls = 0;
        ready_pat = '{1, 0, 0, 1, 1, 1};
        ready_mode = 2;
        @(posedge clk);
        #2;
        put_cmd(0, 20, 23, 50, 0, 6, 0);
        wait_idle(100);
        ready_mode = 0;
        chk("toggle_stalls", stalls, 2);
        chk("toggle_count", acc_log.size(), 4);
        for (int i = 0; i < acc_log.size() && i < 4; i++)
            chk("toggle_log", acc_log[i], 8020 + i);

        // Discards
        acc_log.delete();
        @(posedge clk);
        #2;
        rp = int'(bus.rd_ptr);
        put_cmd(3, 1, 2, 3, 4, 5, 0);
        wait_idle(50);
        chk("nop_rd_ptr", bus.rd_ptr, (rp + 2) % DEPTH);
        @(posedge clk);
        #2;
        put_cmd(0, 10, 4, 3, 0, 1, 0);
        wait_idle(50);
        chk("bad_span_rd_ptr", bus.rd_ptr, (rp + 4) % DEPTH);
        chk("discard_writes", acc_log.size(), 0);

        // Randomised stream with split word writes and random backpressure
        ready_mode = 1;
        for (int n = 0; n < 60; n++) begin
            for (int g = 0; g < 200; g++) begin
                used = bus.wr_ptr - bus.rd_ptr;
                if (used < PTR_W'(DEPTH - 4)) break;
                @(posedge clk);
                #2;
            end
            case ($urandom_range(0, 19))
                0, 1, 2: op = 3;
                3, 4, 5, 6, 7, 8, 9, 10: op = 1;
                default: op = 0;
            endcase
            l = $urandom_range(0, 170);
            if (op == 0 && $urandom_range(0, 3) == 0) r = $urandom_range(0, 255);
            else r = l + $urandom_range(0, 12);
            t = $urandom_range(0, 125);
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 127);
            else b = t + $urandom_range(0, 3);
            if (b > 127) b = 127;
            put_cmd(op, l, r, t, b, $urandom_range(0, 7), $urandom_range(0, 3));
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #2;
        end
        wait_idle(20000);
        ready_mode = 0;

        // Reset with a nearly full queue, then wrap and a half-written command
        @(posedge clk);
        #2;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) pram[i] = word0(3, 0, 0);
        pram[1022] = word0(0, 100, 103);
        pram[1023] = word1(7, 0, 2);
        bus.wr_ptr = PTR_W'(1023);
        #3;
        chk("full_rst_rd_ptr", bus.rd_ptr, 0);
        chk("full_at_reset", bus.full, 1);
        chk("full_rst_busy", bus.busy, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("full_rd_ptr1", bus.rd_ptr, 1);
        chk("full_drop", bus.full, 0);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.rd_ptr == PTR_W'(1023)) break;
        end
        repeat (4) @(negedge clk);
        chk("half_rd_ptr", bus.rd_ptr, 1023);
        chk("half_busy", bus.busy, 1);
        chk("half_we", bus.fb_we, 0);
        acc_log.delete();
        @(posedge clk);
        #2;
        model(0, 100, 103, 7, 0, 2);
        bus.wr_ptr = '0;
        wait_idle(50);
        chk("wrap_rd_ptr", bus.rd_ptr, 0);
        chk("half_count", acc_log.size(), 4);
        if (acc_log.size() > 0) chk("half_first", acc_log[0], 1220);

        // Full-screen clear
        acc_log.delete();
        @(posedge clk);
        #2;
        put_cmd(2, 200, 3, 9, 9, 7, 0);
        wait_idle(20000);
        chk("clear_count", acc_log.size(), H * V);
        if (acc_log.size() == H * V) begin
            chk("clear_first", acc_log[0], 0);
            chk("clear_last", acc_log[H * V - 1], 19199);
        end

        // Reset in the middle of a clear
        @(posedge clk);
        #2;
        put_cmd(2, 0, 0, 0, 0, 4, 0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("midclr_we_before", bus.fb_we, 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midclr_we", bus.fb_we, 0);
        chk("midclr_busy", bus.busy, 0);
        chk("midclr_rd_ptr", bus.rd_ptr, 0);
        exp_a.delete();
        exp_c.delete();
        bus.wr_ptr = '0;
        repeat (3) @(negedge clk);
        chk("midclr_held", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
